iob_pulse_seq: RTL and testbench
================================

// Module: iob_pulse_seq
// PURPOSE
//  Programmable pulse-train sequencer. On a start handshake it latches a burst
//  configuration (initial delay, pulse width, period, pulse count) and drives a
//  registered pulse_out through the programmed burst, then reports done. It
//  sequences timed enables/strobes for peripherals in the int_mem subsystem,
//  replacing fixed-parameter pulse generators where timing must be runtime-set.
// PARAMETERS
//  CNT_W  16  width of delay/width/period config fields and the phase down-counter
//  NUM_W  8   width of the pulse-count config field, pulse counter and pulse_idx
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  start       in   1      start request; honoured only in IDLE
//  abort       in   1      stop the burst immediately
//  cfg_delay   in   CNT_W  cycles between start acceptance and the first rising edge
//  cfg_width   in   CNT_W  pulse high time, cycles (>=1)
//  cfg_period  in   CNT_W  rising edge to rising edge, cycles (>cfg_width)
//  cfg_count   in   NUM_W  pulses per burst (>=1)
//  busy        out  1      sequencer is not in IDLE
//  pulse_out   out  1      registered pulse train
//  pulse_idx   out  NUM_W  0-based index of the current/last pulse; holds when idle
//  done        out  1      1-cycle strobe: burst completed normally
//  err         out  1      1-cycle strobe: start rejected (bad config)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, pulse_out, done, err = 0; pulse_idx = 0; counters = 0.
//  - FSM states: IDLE, DELAY, HIGH, LOW, DONE. busy=(state!=IDLE); pulse_out=(state==HIGH).
//  - Start: sampled in IDLE at cycle t. Config is valid iff width>=1, count>=1 and
//    period>width. Valid config -> cfg latched into shadow regs, pulse_idx=0, and the
//    next state at t+1 is DELAY (delay>0) or HIGH (delay==0). Invalid -> err=1 at t+1,
//    stay IDLE.
//  - First rising edge of pulse_out is at cycle t+1+cfg_delay.
//  - DELAY lasts cfg_delay cycles. HIGH lasts cfg_width cycles. LOW lasts
//    cfg_period-cfg_width cycles.
//  - After HIGH: if this is the last pulse (pulse_idx==count-1), go to DONE; else go
//    to LOW. LOW -> HIGH with pulse_idx+1. No trailing LOW after the last pulse.
//  - DONE lasts 1 cycle with done=1, then IDLE.
//  - Counting: one CNT_W down-counter is loaded with (phase length - 1) on each phase
//    entry; the phase exits when the counter is 0. No wrap: the period-width
//    subtraction is only done on validated config, so it is always >=1.
//  - Shadow config: cfg_* changes while busy have no effect on the running burst.
//  - start while busy (DELAY/HIGH/LOW/DONE): ignored. No queueing, no err.
//  - abort in any non-IDLE state: the next cycle is IDLE with pulse_out=0 and no done.
//    pulse_idx holds.
//  - abort and start together in IDLE: abort wins. start is ignored, no err.
//  - rst mid-burst: all outputs are at reset values the next cycle.
//  - Max values: cfg_count=2^NUM_W-1 and all-ones delay/period are legal. pulse_idx
//    never wraps.
// TESTING
//  - delay=2,width=3,period=5,count=3, start@0 -> pulse_out=1 @3-5,8-10,13-15; done@16;
//    busy@1-16; pulse_idx 0,1,2.
//  - delay=0,width=1,period=2,count=1, start@0 -> pulse_out=1 @1 only; done@2; busy@1-2.
//  - width=0 or count=0 or period=width (4,4) -> err=1 the next cycle; busy stays 0;
//    pulse_out stays 0.
//  - Case-1 config, abort@9 -> pulse_out=0 and busy=0 from 10; done never asserts;
//    pulse_idx=1.
//  - Case-1 config; start pulsed again @5 and cfg_width changed to 7 @5 -> the
//    waveform is identical to case 1.
//  - rst@7 during case 1 -> all outputs 0 from 8; a start@10 with case-1 config
//    reproduces the case-1 timing offset by 10.

Source files
------------

// File: rtl/iob_pulse_seq.sv
// Programmable pulse-train sequencer: a start request latches a burst
// configuration, plays delay/high/low phases for N pulses, then strobes done.
module iob_pulse_seq #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NUM_W-1:0] cfg_count,
    output logic             busy,
    output logic             pulse_out,
    output logic [NUM_W-1:0] pulse_idx,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] C1 = 1;
    localparam logic [NUM_W-1:0] N1 = 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] sh_width, sh_period;
    logic [NUM_W-1:0] sh_count;
    logic [NUM_W-1:0] idx, idx_n;
    logic             err_n;
    logic             load;
    logic             cfg_ok;

    assign cfg_ok = (cfg_width != '0) && (cfg_count != '0)
                    && (cfg_period > cfg_width);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            err       <= 1'b0;
            sh_width  <= '0;
            sh_period <= '0;
            sh_count  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            err   <= err_n;
            if (load) begin
                sh_width  <= cfg_width;
                sh_period <= cfg_period;
                sh_count  <= cfg_count;
            end
        end
    end

    // cnt holds (remaining cycles - 1) of the current phase
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        err_n   = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        load  = 1'b1;
                        idx_n = '0;
                        if (cfg_delay != '0) begin
                            state_n = DELAY;
                            cnt_n   = cfg_delay - C1;
                        end else begin
                            state_n = HIGH;
                            cnt_n   = cfg_width - C1;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    state_n = HIGH;
                    cnt_n   = sh_width - C1;
                end else begin
                    cnt_n = cnt - C1;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    if (idx == sh_count - N1) begin
                        state_n = DONE;
                        cnt_n   = '0;
                    end else begin
                        state_n = LOW;
                        cnt_n   = sh_period - sh_width - C1;
                    end
                end else begin
                    cnt_n = cnt - C1;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    state_n = HIGH;
                    cnt_n   = sh_width - C1;
                    idx_n   = idx + N1;
                end else begin
                    cnt_n = cnt - C1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = idx;
        end
    end

    always_comb begin
        busy      = 1'b0;
        pulse_out = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        pulse_out = (state == HIGH);
        done      = (state == DONE);
    end

    assign pulse_idx = idx;

endmodule

// File: tb/tb_iob_pulse_seq.sv
// Bench for iob_pulse_seq: burst-level reference model checked every cycle,
// a table of configurations, hand sequences for abort/restart/reset corners.
module tb_iob_pulse_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_count;
    logic        busy;
    logic        pulse_out;
    logic [7:0]  pulse_idx;
    logic        done;
    logic        err;

    iob_pulse_seq #(.CNT_W(16), .NUM_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .busy       (busy),
        .pulse_out  (pulse_out),
        .pulse_idx  (pulse_idx),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    longint cyc   = 0;

    // burst model: one record of the running burst, evaluated arithmetically
    bit     m_act = 0;
    longint m_t, m_d, m_w, m_p, m_n;
    longint m_hold = 0;
    bit     m_err = 0;

    function automatic void exp_at(input longint c, output bit b,
                                   output bit p, output bit d,
                                   output longint idx);
        longint rel, last, q, k;
        b = 0; p = 0; d = 0; idx = m_hold;
        if (m_act) begin
            rel  = c - m_t - 1;
            last = m_d + (m_n - 1) * m_p + m_w;
            b    = 1;
            d    = (rel == last);
            idx  = 0;
            if (rel >= m_d) begin
                q   = rel - m_d;
                k   = q / m_p;
                p   = (k < m_n) && ((q % m_p) < m_w);
                idx = (k > m_n - 1) ? m_n - 1 : k;
            end
        end
    endfunction

    task automatic check(input string name, input longint got,
                         input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    task automatic step();
        bit     pb, pp, pd, ps, pa, pr;
        longint pidx, d, w, p, n;
        bit     eb, ep, ed;
        longint eidx;
        ps = start; pa = abort; pr = rst;
        d = cfg_delay; w = cfg_width; p = cfg_period; n = cfg_count;
        exp_at(cyc, pb, pp, pd, pidx);
        @(posedge clk);
        #1;
        cyc++;
        m_err = 0;
        if (pr) begin
            m_act  = 0;
            m_hold = 0;
        end else if (m_act) begin
            if (pa || pd) begin
                m_act  = 0;
                m_hold = pidx;
            end
        end else if (ps && !pa) begin
            if (w >= 1 && n >= 1 && p > w) begin
                m_act = 1; m_t = cyc - 1;
                m_d = d; m_w = w; m_p = p; m_n = n;
            end else begin
                m_err = 1;
            end
        end
        exp_at(cyc, eb, ep, ed, eidx);
        tests++;
        if (busy !== eb || pulse_out !== ep || done !== ed
            || err !== m_err || pulse_idx !== 8'(eidx)) begin
            fails++;
            $display("FAIL model c%0d: busy %b/%b pulse %b/%b done %b/%b err %b/%b idx %0d/%0d",
                     cyc, busy, eb, pulse_out, ep, done, ed, err, m_err,
                     pulse_idx, eidx);
        end
    endtask

    task automatic set_cfg(input int d, input int w, input int p,
                           input int n);
        cfg_delay  = 16'(d);
        cfg_width  = 16'(w);
        cfg_period = 16'(p);
        cfg_count  = 8'(n);
    endtask

    // start at the current cycle, run to idle; report offsets of first
    // rising edge and of done relative to the start cycle
    task automatic run_burst(output int fr, output int da,
                             output bit got_err);
        longint s;
        s = cyc;
        fr = -1; da = -1;
        start = 1;
        step();
        start = 0;
        got_err = err;
        for (int i = 0; i < 700; i++) begin
            if (pulse_out && fr < 0) fr = int'(cyc - s);
            if (done && da < 0) da = int'(cyc - s);
            if (!busy) break;
            step();
        end
    endtask

    typedef struct {
        int d, w, p, n;
        bit e_err;
        int e_rise;
        int e_done;
    } vec_t;

    vec_t vecs[8];
    int   fr, da;
    bit   ge;
    bit   saw_done;
    longint s0;

    initial begin
        vecs[0] = '{2, 3, 5, 3, 0, 3, 16};
        vecs[1] = '{0, 1, 2, 1, 0, 1, 2};
        vecs[2] = '{0, 0, 4, 1, 1, -1, -1};
        vecs[3] = '{1, 2, 4, 0, 1, -1, -1};
        vecs[4] = '{0, 4, 4, 2, 1, -1, -1};
        vecs[5] = '{1, 2, 3, 2, 0, 2, 7};
        vecs[6] = '{0, 1, 2, 3, 0, 1, 6};
        vecs[7] = '{3, 1, 10, 2, 0, 4, 15};

        rst = 1; start = 0; abort = 0;
        set_cfg(0, 0, 0, 0);
        step();
        step();
        check("reset_busy", busy, 0);
        check("reset_idx", pulse_idx, 0);
        rst = 0;
        step();

        foreach (vecs[i]) begin
            set_cfg(vecs[i].d, vecs[i].w, vecs[i].p, vecs[i].n);
            run_burst(fr, da, ge);
            check($sformatf("vec%0d_err", i), ge, vecs[i].e_err);
            check($sformatf("vec%0d_rise", i), fr, vecs[i].e_rise);
            check($sformatf("vec%0d_done", i), da, vecs[i].e_done);
            step();
        end

        // abort at cycle 9 of the reference burst
        set_cfg(2, 3, 5, 3);
        s0 = cyc;
        start = 1; step(); start = 0;
        while (cyc < s0 + 9) step();
        abort = 1; step(); abort = 0;
        check("abort_busy", busy, 0);
        check("abort_pulse", pulse_out, 0);
        check("abort_idx", pulse_idx, 1);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);

        // restart and cfg change while busy have no effect
        set_cfg(2, 3, 5, 3);
        s0 = cyc; fr = -1; da = -1;
        start = 1; step(); start = 0;
        for (int i = 0; i < 30; i++) begin
            if (cyc == s0 + 5) begin
                start = 1; cfg_width = 16'd7;
            end else begin
                start = 0;
            end
            if (pulse_out && fr < 0) fr = int'(cyc - s0);
            if (done && da < 0) da = int'(cyc - s0);
            step();
        end
        check("restart_rise", fr, 3);
        check("restart_done", da, 16);

        // reset mid-burst, then a fresh burst 10 cycles after the first start
        set_cfg(2, 3, 5, 3);
        s0 = cyc;
        start = 1; step(); start = 0;
        while (cyc < s0 + 7) step();
        rst = 1; step(); rst = 0;
        check("rst_busy", busy, 0);
        check("rst_pulse", pulse_out, 0);
        check("rst_done", done, 0);
        while (cyc < s0 + 10) step();
        run_burst(fr, da, ge);
        check("rst_rerun_rise", fr, 3);
        check("rst_rerun_done", da, 16);
        step();

        // abort wins over start in idle, even with a bad config
        set_cfg(0, 0, 3, 1);
        start = 1; abort = 1; step();
        check("abort_start_err", err, 0);
        set_cfg(0, 1, 3, 1);
        step();
        check("abort_start_busy", busy, 0);
        start = 0; abort = 0;
        step();

        // max pulse count: index climbs to 254 without wrapping
        set_cfg(0, 1, 2, 255);
        run_burst(fr, da, ge);
        check("max_done", da, 510);
        check("max_idx", pulse_idx, 254);
        step();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 49) == 0);
            set_cfg($urandom_range(0, 5), $urandom_range(0, 4),
                    $urandom_range(0, 8), $urandom_range(0, 4));
            step();
        end
        rst = 0; start = 0; abort = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
